// File: rtl/rv_fetch_queue_if.sv
// Fetch-unit bundle: instruction memory read port, decode-side queue head, branch redirect.
// master = fetch unit, slave = memory/decode/execute environment.
interface rv_fetch_queue_if;
  logic [31:0] im_addr_o;
  logic        im_rd_o;
  logic [31:0] im_data_i;
  logic        im_valid_i;
  logic        f_stall_i;
  logic [31:0] f_ir_o;
  logic [31:0] f_pc_o;
  logic        f_ir_valid_o;
  logic [31:0] x_pc_bra_i;
  logic        x_bra_i;

  modport master (
    output im_addr_o, im_rd_o, f_ir_o, f_pc_o, f_ir_valid_o,
    input  im_data_i, im_valid_i, f_stall_i, x_pc_bra_i, x_bra_i
  );

  modport slave (
    input  im_addr_o, im_rd_o, f_ir_o, f_pc_o, f_ir_valid_o,
    output im_data_i, im_valid_i, f_stall_i, x_pc_bra_i, x_bra_i
  );
endinterface

// File: rtl/rv_fetch_queue.sv
// Instruction fetch unit: prefetch FIFO with multiple outstanding in-order reads,
// flush on branch redirect with counted discard of stale in-flight responses.
module rv_fetch_queue #(
  parameter logic [31:0] RESET_VECTOR = 32'h0,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input logic               clk_i,
  input logic               rst_i,
  rv_fetch_queue_if.master  bus
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 1;
  localparam logic [31:0] RV_ALIGNED = RESET_VECTOR & 32'hFFFF_FFFC;

  logic [31:0]   req_pc_q, req_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] live_q, live_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   ir_mem_q [FIFO_DEPTH];
  logic [31:0]   pc_mem_q [FIFO_DEPTH];

  logic          bra_c;
  logic [31:0]   tgt_c;
  logic          room_c;
  logic          issue_c;
  logic          push_c;
  logic          discard_c;
  logic          pop_c;
  logic [CW-1:0] pend_c;

  // Issue/response/pop/branch decisions; all headroom checks use registered counts.
  always_comb begin
    req_pc_d  = req_pc_q;
    resp_pc_d = resp_pc_q;
    live_d    = live_q;
    drop_d    = drop_q;
    cnt_d     = cnt_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;

    bra_c     = bus.x_bra_i;
    tgt_c     = bus.x_pc_bra_i & 32'hFFFF_FFFC;
    room_c    = ((SW'(cnt_q) + SW'(live_q)) < SW'(FIFO_DEPTH)) &&
                ((SW'(live_q) + SW'(drop_q)) < SW'(FIFO_DEPTH));
    issue_c   = !rst_i && !bra_c && room_c;
    discard_c = bus.im_valid_i && !bra_c && (drop_q != '0);
    push_c    = bus.im_valid_i && !bra_c && (drop_q == '0) && (live_q != '0);
    pop_c     = (cnt_q != '0) && !bus.f_stall_i && !bra_c;
    pend_c    = drop_q + live_q;

    if (bra_c) begin
      // Every read still in flight becomes stale; a response arriving now retires one.
      drop_d    = (bus.im_valid_i && (pend_c != '0)) ? pend_c - CW'(1) : pend_c;
      live_d    = '0;
      cnt_d     = '0;
      wr_ptr_d  = rd_ptr_q;
      req_pc_d  = tgt_c;
      resp_pc_d = tgt_c;
    end else begin
      drop_d    = drop_q - CW'(discard_c);
      live_d    = live_q + CW'(issue_c) - CW'(push_c);
      cnt_d     = cnt_q + CW'(push_c) - CW'(pop_c);
      wr_ptr_d  = wr_ptr_q + PW'(push_c);
      rd_ptr_d  = rd_ptr_q + PW'(pop_c);
      req_pc_d  = req_pc_q + (issue_c ? 32'd4 : 32'd0);
      resp_pc_d = resp_pc_q + (push_c ? 32'd4 : 32'd0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_pc_q  <= RV_ALIGNED;
      resp_pc_q <= RV_ALIGNED;
      live_q    <= '0;
      drop_q    <= '0;
      cnt_q     <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        ir_mem_q[i] <= '0;
        pc_mem_q[i] <= '0;
      end
    end else begin
      req_pc_q  <= req_pc_d;
      resp_pc_q <= resp_pc_d;
      live_q    <= live_d;
      drop_q    <= drop_d;
      cnt_q     <= cnt_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      if (push_c) begin
        ir_mem_q[wr_ptr_q] <= bus.im_data_i;
        pc_mem_q[wr_ptr_q] <= resp_pc_q;
      end
    end
  end

  assign bus.im_addr_o    = req_pc_q & 32'hFFFF_FFFC;
  assign bus.im_rd_o      = issue_c;
  assign bus.f_ir_o       = ir_mem_q[rd_ptr_q];
  assign bus.f_pc_o       = pc_mem_q[rd_ptr_q];
  assign bus.f_ir_valid_o = (cnt_q != '0);
endmodule

// File: tb/tb_rv_fetch_queue.sv
// Directed bench for rv_fetch_queue: variable-latency in-order memory model,
// request/delivery logs, per-scenario tasks with hand-derived expectations.
module tb_rv_fetch_queue;
  typedef struct {
    logic [31:0] a;
    int          c;
  } ev_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    int          c;
  } del_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   lat = 1;

  ev_t  req_q[$];
  ev_t  pend_q[$];
  del_t del_q[$];

  rv_fetch_queue_if bus();

  rv_fetch_queue #(.RESET_VECTOR(32'h0), .FIFO_DEPTH(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {~a[15:0], a[31:16]};
  endfunction

  // In-order memory: request in cycle N answers in cycle N+lat.
  initial begin
    ev_t e;
    bus.im_valid_i = 1'b0;
    bus.im_data_i  = 32'h0;
    forever begin
      @(posedge clk);
      if (rst) pend_q.delete();
      else if (bus.im_rd_o === 1'b1) begin
        e.a = bus.im_addr_o;
        e.c = cyc + lat;
        pend_q.push_back(e);
      end
      #1;
      if (pend_q.size() > 0 && pend_q[0].c <= cyc) begin
        bus.im_valid_i = 1'b1;
        bus.im_data_i  = memf(pend_q[0].a);
        void'(pend_q.pop_front());
      end else begin
        bus.im_valid_i = 1'b0;
        bus.im_data_i  = 32'h0;
      end
    end
  end

  // Mid-cycle log of issued requests and consumed instructions.
  always @(negedge clk) begin
    ev_t  e;
    del_t d;
    if (bus.im_rd_o === 1'b1) begin
      e.a = bus.im_addr_o;
      e.c = cyc;
      req_q.push_back(e);
    end
    if (!rst && bus.f_ir_valid_o === 1'b1 && !bus.f_stall_i && !bus.x_bra_i) begin
      d.pc = bus.f_pc_o;
      d.ir = bus.f_ir_o;
      d.c  = cyc;
      del_q.push_back(d);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(output int s);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    req_q.delete();
    del_q.delete();
    s = cyc;
  endtask

  task automatic test_reset;
    bus.f_stall_i  = 1'b0;
    bus.x_bra_i    = 1'b0;
    bus.x_pc_bra_i = 32'h0;
    rst = 1'b1;
    tick(2);
    checks++; if (bus.im_rd_o !== 1'b0) begin failures++; $display("FAIL reset_im_rd got=%0h exp=0", bus.im_rd_o); end
    checks++; if (bus.f_ir_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", bus.f_ir_valid_o); end
    checks++; if (bus.f_ir_o !== 32'h0) begin failures++; $display("FAIL reset_ir got=%h exp=0", bus.f_ir_o); end
    checks++; if (bus.f_pc_o !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", bus.f_pc_o); end
    checks++; if (bus.im_addr_o !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", bus.im_addr_o); end
  endtask

  task automatic test_stream;
    int s;
    lat = 1;
    apply_reset(s);
    tick(10);
    checks++;
    if (req_q.size() < 4) begin failures++; $display("FAIL stream_req_count got=%0d exp>=4", req_q.size()); end
    else for (int k = 0; k < 4; k++) begin
      checks++; if (req_q[k].a !== 32'(4 * k) || req_q[k].c != s + k) begin
        failures++; $display("FAIL stream_req%0d got=%h@%0d exp=%h@%0d", k, req_q[k].a, req_q[k].c, 4 * k, s + k); end
    end
    checks++;
    if (del_q.size() < 6) begin failures++; $display("FAIL stream_del_count got=%0d exp>=6", del_q.size()); end
    else for (int k = 0; k < 6; k++) begin
      checks++; if (del_q[k].pc !== 32'(4 * k) || del_q[k].ir !== memf(32'(4 * k)) || del_q[k].c != s + 2 + k) begin
        failures++; $display("FAIL stream_del%0d got=%h/%h@%0d exp=%h/%h@%0d", k, del_q[k].pc, del_q[k].ir,
                             del_q[k].c, 4 * k, memf(32'(4 * k)), s + 2 + k); end
    end
  endtask

  task automatic test_stall;
    int s;
    int t;
    lat = 1;
    bus.f_stall_i = 1'b1;
    apply_reset(s);
    tick(10);
    checks++; if (req_q.size() != 4) begin failures++; $display("FAIL stall_req_count got=%0d exp=4", req_q.size()); end
    checks++; if (bus.im_rd_o !== 1'b0) begin failures++; $display("FAIL stall_im_rd got=%0h exp=0", bus.im_rd_o); end
    checks++; if (bus.f_ir_valid_o !== 1'b1) begin failures++; $display("FAIL stall_valid got=%0h exp=1", bus.f_ir_valid_o); end
    del_q.delete();
    bus.f_stall_i = 1'b0;
    t = cyc;
    tick(10);
    checks++;
    if (del_q.size() < 8) begin failures++; $display("FAIL drain_count got=%0d exp>=8", del_q.size()); end
    else for (int k = 0; k < 8; k++) begin
      checks++; if (del_q[k].pc !== 32'(4 * k) || del_q[k].c != t + k) begin
        failures++; $display("FAIL drain%0d got=%h@%0d exp=%h@%0d", k, del_q[k].pc, del_q[k].c, 4 * k, t + k); end
    end
  endtask

  task automatic test_branch_latency;
    int s;
    int stale;
    lat = 3;
    apply_reset(s);
    tick(3);
    bus.x_bra_i    = 1'b1;
    bus.x_pc_bra_i = 32'h100;
    #1;
    checks++; if (bus.im_rd_o !== 1'b0) begin failures++; $display("FAIL bra3_rd_in_branch got=%0h exp=0", bus.im_rd_o); end
    tick(1);
    bus.x_bra_i = 1'b0;
    #1;
    checks++; if (bus.im_rd_o !== 1'b1 || bus.im_addr_o !== 32'h100) begin
      failures++; $display("FAIL bra3_first_req got=%0h/%h exp=1/00000100", bus.im_rd_o, bus.im_addr_o); end
    tick(10);
    checks++;
    if (del_q.size() < 3) begin failures++; $display("FAIL bra3_del_count got=%0d exp>=3", del_q.size()); end
    else begin
      checks++; if (del_q[0].pc !== 32'h100 || del_q[0].ir !== memf(32'h100) || del_q[0].c != s + 8) begin
        failures++; $display("FAIL bra3_head got=%h/%h@%0d exp=00000100/%h@%0d", del_q[0].pc, del_q[0].ir,
                             del_q[0].c, memf(32'h100), s + 8); end
      for (int k = 1; k < 3; k++) begin
        checks++; if (del_q[k].pc !== 32'(32'h100 + 4 * k) || del_q[k].ir !== memf(32'(32'h100 + 4 * k))) begin
          failures++; $display("FAIL bra3_del%0d got=%h/%h exp=%h", k, del_q[k].pc, del_q[k].ir, 32'h100 + 4 * k); end
      end
    end
    stale = 0;
    foreach (del_q[i]) if (del_q[i].pc < 32'h100) stale++;
    checks++; if (stale != 0) begin failures++; $display("FAIL bra3_stale got=%0d exp=0", stale); end
  endtask

  task automatic test_branch_collision;
    int s;
    lat = 2;
    apply_reset(s);
    tick(5);
    checks++; if (bus.f_ir_valid_o !== 1'b1 || bus.im_valid_i !== 1'b1 || bus.f_pc_o !== 32'h8) begin
      failures++; $display("FAIL coll_pre got=%0h/%0h/%h exp=1/1/00000008", bus.f_ir_valid_o, bus.im_valid_i, bus.f_pc_o); end
    bus.x_bra_i    = 1'b1;
    bus.x_pc_bra_i = 32'h300;
    tick(1);
    bus.x_bra_i = 1'b0;
    checks++; if (bus.f_ir_valid_o !== 1'b0) begin failures++; $display("FAIL coll_flush got=%0h exp=0", bus.f_ir_valid_o); end
    tick(8);
    checks++;
    if (del_q.size() < 4) begin failures++; $display("FAIL coll_del_count got=%0d exp>=4", del_q.size()); end
    else begin
      checks++; if (del_q[1].pc !== 32'h4 || del_q[1].c != s + 4) begin
        failures++; $display("FAIL coll_before got=%h@%0d exp=00000004@%0d", del_q[1].pc, del_q[1].c, s + 4); end
      checks++; if (del_q[2].pc !== 32'h300 || del_q[2].ir !== memf(32'h300) || del_q[2].c != s + 9) begin
        failures++; $display("FAIL coll_target got=%h/%h@%0d exp=00000300/%h@%0d", del_q[2].pc, del_q[2].ir,
                             del_q[2].c, memf(32'h300), s + 9); end
      checks++; if (del_q[3].pc !== 32'h304 || del_q[3].ir !== memf(32'h304)) begin
        failures++; $display("FAIL coll_next got=%h/%h exp=00000304/%h", del_q[3].pc, del_q[3].ir, memf(32'h304)); end
    end
  endtask

  task automatic test_branch_align;
    int s;
    int bad;
    lat = 1;
    apply_reset(s);
    tick(4);
    bus.x_bra_i    = 1'b1;
    bus.x_pc_bra_i = 32'h203;
    tick(1);
    bus.x_bra_i = 1'b0;
    #1;
    checks++; if (bus.im_rd_o !== 1'b1 || bus.im_addr_o !== 32'h200) begin
      failures++; $display("FAIL align_addr got=%0h/%h exp=1/00000200", bus.im_rd_o, bus.im_addr_o); end
    tick(4);
    req_q.delete();
    del_q.delete();
    bus.x_bra_i    = 1'b1;
    bus.x_pc_bra_i = 32'h40;
    tick(1);
    bus.x_pc_bra_i = 32'h80;
    tick(1);
    bus.x_bra_i = 1'b0;
    tick(8);
    checks++;
    if (req_q.size() < 1 || del_q.size() < 4) begin
      failures++; $display("FAIL b2b_counts got=%0d/%0d exp>=1/>=4", req_q.size(), del_q.size()); end
    else begin
      checks++; if (req_q[0].a !== 32'h80) begin failures++; $display("FAIL b2b_first_req got=%h exp=00000080", req_q[0].a); end
      for (int k = 0; k < 4; k++) begin
        checks++; if (del_q[k].pc !== 32'(32'h80 + 4 * k) || del_q[k].ir !== memf(32'(32'h80 + 4 * k))) begin
          failures++; $display("FAIL b2b_del%0d got=%h/%h exp=%h", k, del_q[k].pc, del_q[k].ir, 32'h80 + 4 * k); end
      end
    end
    bad = 0;
    foreach (req_q[i]) if (req_q[i].a >= 32'h40 && req_q[i].a < 32'h80) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL b2b_loser_reqs got=%0d exp=0", bad); end
  endtask

  task automatic test_pc_wrap;
    int s;
    logic [31:0] exp_pc [4];
    exp_pc[0] = 32'hFFFF_FFF8;
    exp_pc[1] = 32'hFFFF_FFFC;
    exp_pc[2] = 32'h0000_0000;
    exp_pc[3] = 32'h0000_0004;
    lat = 1;
    apply_reset(s);
    tick(3);
    bus.x_bra_i    = 1'b1;
    bus.x_pc_bra_i = 32'hFFFF_FFF8;
    tick(1);
    bus.x_bra_i = 1'b0;
    del_q.delete();
    tick(8);
    checks++;
    if (del_q.size() < 4) begin failures++; $display("FAIL wrap_count got=%0d exp>=4", del_q.size()); end
    else for (int k = 0; k < 4; k++) begin
      checks++; if (del_q[k].pc !== exp_pc[k] || del_q[k].ir !== memf(exp_pc[k])) begin
        failures++; $display("FAIL wrap%0d got=%h/%h exp=%h/%h", k, del_q[k].pc, del_q[k].ir, exp_pc[k], memf(exp_pc[k])); end
    end
  endtask

  task automatic test_mid_reset;
    int s;
    int r;
    lat = 2;
    apply_reset(s);
    tick(6);
    rst = 1'b1;
    tick(2);
    checks++; if (bus.f_ir_valid_o !== 1'b0 || bus.im_rd_o !== 1'b0) begin
      failures++; $display("FAIL midrst_state got=%0h/%0h exp=0/0", bus.f_ir_valid_o, bus.im_rd_o); end
    rst = 1'b0;
    req_q.delete();
    del_q.delete();
    r = cyc;
    tick(8);
    checks++;
    if (req_q.size() < 1 || del_q.size() < 2) begin
      failures++; $display("FAIL midrst_counts got=%0d/%0d exp>=1/>=2", req_q.size(), del_q.size()); end
    else begin
      checks++; if (req_q[0].a !== 32'h0 || req_q[0].c != r) begin
        failures++; $display("FAIL midrst_req got=%h@%0d exp=00000000@%0d", req_q[0].a, req_q[0].c, r); end
      checks++; if (del_q[0].pc !== 32'h0 || del_q[0].ir !== memf(32'h0) || del_q[0].c != r + 3) begin
        failures++; $display("FAIL midrst_del0 got=%h/%h@%0d exp=00000000/%h@%0d", del_q[0].pc, del_q[0].ir,
                             del_q[0].c, memf(32'h0), r + 3); end
      checks++; if (del_q[1].pc !== 32'h4) begin failures++; $display("FAIL midrst_del1 got=%h exp=00000004", del_q[1].pc); end
    end
  endtask

  initial begin
    bus.f_stall_i  = 1'b0;
    bus.x_bra_i    = 1'b0;
    bus.x_pc_bra_i = 32'h0;
    test_reset();
    test_stream();
    test_stall();
    test_branch_latency();
    test_branch_collision();
    test_branch_align();
    test_pc_wrap();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
